target_select_fsm: RTL and testbench



---
 rtl/target_select_fsm.sv | 220 ++++++++++++++++++++++
 tb/tb_target_select_fsm.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/target_select_fsm.sv
// Mode/coordinate controller feeding the seven-segment driver: selects ultrasonic or keyboard
// entry, filters PS/2 bytes into digits and quantises distance samples into 0..9 bins.
module target_select_fsm #(
    parameter int unsigned BIN_CM = 10,
    parameter int unsigned DIST_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_ultra,
    input  logic              btn_key,
    input  logic              btn_back,
    input  logic              key_valid,
    input  logic [7:0]        key_code,
    input  logic              dist_valid,
    input  logic              dist_axis,
    input  logic [DIST_W-1:0] dist_cm,
    output logic [1:0]        state,
    output logic [3:0]        x,
    output logic [3:0]        y,
    output logic              target_valid,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_SEL   = 2'b00,
        ST_ULTRA = 2'b01,
        ST_KEYB  = 2'b10,
        ST_BAD   = 2'b11
    } state_t;

    localparam logic [3:0]        UNSET   = 4'hF;
    localparam logic [3:0]        MAX_BIN = 4'd9;
    localparam logic [DIST_W-1:0] BIN     = DIST_W'(BIN_CM);
    localparam logic [7:0]        KC_REL  = 8'hF0;
    localparam logic [7:0]        KC_EXT  = 8'hE0;
    localparam logic [7:0]        KC_BKSP = 8'h66;
    localparam logic [7:0]        KC_ENT  = 8'h5A;
    localparam logic [7:0]        KC_ESC  = 8'h76;

    state_t            state_q, state_d;
    logic [3:0]        x_q, x_d, y_q, y_d;
    logic              tv_q, tv_d, busy_q, busy_d;
    logic [1:0]        idx_q, idx_d;
    logic              rel_q, rel_d, ext_q, ext_d;
    logic [DIST_W-1:0] rem_q, rem_d;
    logic [3:0]        quo_q, quo_d;
    logic              axis_q, axis_d;
    logic              prev_u_q, prev_k_q, prev_b_q;
    logic              edge_u, edge_k, edge_b;
    logic              go_sel, enter;
    logic [4:0]        dig;

    // {valid, digit} for a set-2 make code
    function automatic logic [4:0] decode_digit(input logic [7:0] code);
        logic [4:0] r;
        r = 5'b0;
        case (code)
            8'h45: r = {1'b1, 4'd0};
            8'h16: r = {1'b1, 4'd1};
            8'h1E: r = {1'b1, 4'd2};
            8'h26: r = {1'b1, 4'd3};
            8'h25: r = {1'b1, 4'd4};
            8'h2E: r = {1'b1, 4'd5};
            8'h36: r = {1'b1, 4'd6};
            8'h3D: r = {1'b1, 4'd7};
            8'h3E: r = {1'b1, 4'd8};
            8'h46: r = {1'b1, 4'd9};
            default: r = 5'b0;
        endcase
        return r;
    endfunction

    assign edge_u = btn_ultra & ~prev_u_q;
    assign edge_k = btn_key   & ~prev_k_q;
    assign edge_b = btn_back  & ~prev_b_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        tv_d    = 1'b0;
        busy_d  = busy_q;
        idx_d   = idx_q;
        rel_d   = rel_q;
        ext_d   = ext_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        axis_d  = axis_q;
        go_sel  = 1'b0;
        enter   = 1'b0;
        dig     = decode_digit(key_code);

        case (state_q)
            ST_SEL: begin
                x_d    = UNSET;
                y_d    = UNSET;
                busy_d = 1'b0;
                if (edge_u && !edge_k) begin
                    state_d = ST_ULTRA;
                    enter   = 1'b1;
                end else if (edge_k && !edge_u) begin
                    state_d = ST_KEYB;
                    enter   = 1'b1;
                end
            end
            ST_ULTRA: begin
                if (edge_b) begin
                    go_sel = 1'b1;
                end else if (busy_q) begin
                    // one subtract per cycle, clamped at bin 9
                    if (rem_q >= BIN && quo_q < MAX_BIN) begin
                        rem_d = rem_q - BIN;
                        quo_d = quo_q + 4'd1;
                    end else begin
                        if (axis_q) y_d = quo_q;
                        else        x_d = quo_q;
                        tv_d   = 1'b1;
                        busy_d = 1'b0;
                    end
                end else if (dist_valid) begin
                    rem_d  = dist_cm;
                    axis_d = dist_axis;
                    quo_d  = 4'd0;
                    busy_d = 1'b1;
                end
            end
            ST_KEYB: begin
                if (edge_b) begin
                    go_sel = 1'b1;
                end else if (key_valid) begin
                    if (key_code == KC_REL) begin
                        rel_d = 1'b1;
                    end else if (key_code == KC_EXT) begin
                        ext_d = 1'b1;
                    end else if (rel_q || ext_q) begin
                        rel_d = 1'b0;
                        ext_d = 1'b0;
                    end else if (dig[4]) begin
                        if (idx_q == 2'd0) begin
                            x_d   = dig[3:0];
                            idx_d = 2'd1;
                        end else if (idx_q == 2'd1) begin
                            y_d   = dig[3:0];
                            idx_d = 2'd2;
                        end
                    end else if (key_code == KC_BKSP) begin
                        if (idx_q == 2'd2) begin
                            y_d   = UNSET;
                            idx_d = 2'd1;
                        end else if (idx_q == 2'd1) begin
                            x_d   = UNSET;
                            idx_d = 2'd0;
                        end
                    end else if (key_code == KC_ENT && idx_q == 2'd2) begin
                        tv_d  = 1'b1;
                        idx_d = 2'd0;
                    end else if (key_code == KC_ESC) begin
                        go_sel = 1'b1;
                    end
                end
            end
            default: go_sel = 1'b1;
        endcase

        // back/escape wins over any same-cycle event and aborts the divider
        if (go_sel) begin
            state_d = ST_SEL;
            x_d     = UNSET;
            y_d     = UNSET;
            tv_d    = 1'b0;
            busy_d  = 1'b0;
        end
        if (enter) begin
            x_d   = UNSET;
            y_d   = UNSET;
            idx_d = 2'd0;
            rel_d = 1'b0;
            ext_d = 1'b0;
        end
    end

    // button history follows the level during reset so a held button never fires
    always_ff @(posedge clk) begin
        prev_u_q <= btn_ultra;
        prev_k_q <= btn_key;
        prev_b_q <= btn_back;
        if (reset) begin
            state_q <= ST_SEL;
            x_q     <= UNSET;
            y_q     <= UNSET;
            tv_q    <= 1'b0;
            busy_q  <= 1'b0;
            idx_q   <= 2'd0;
            rel_q   <= 1'b0;
            ext_q   <= 1'b0;
            rem_q   <= '0;
            quo_q   <= 4'd0;
            axis_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            tv_q    <= tv_d;
            busy_q  <= busy_d;
            idx_q   <= idx_d;
            rel_q   <= rel_d;
            ext_q   <= ext_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            axis_q  <= axis_d;
        end
    end

    assign state        = state_q;
    assign x            = x_q;
    assign y            = y_q;
    assign target_valid = tv_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_target_select_fsm.sv
// Bench for target_select_fsm: directed scenarios plus random traffic against a
// cycle-level behavioural model of modes, key entry and binned distance results.
module tb_target_select_fsm;

    localparam int unsigned BIN_CM = 10;
    localparam int unsigned DIST_W = 9;

    logic              clk = 1'b0;
    logic              reset;
    logic              btn_ultra, btn_key, btn_back;
    logic              key_valid;
    logic [7:0]        key_code;
    logic              dist_valid, dist_axis;
    logic [DIST_W-1:0] dist_cm;
    logic [1:0]        state;
    logic [3:0]        x, y;
    logic              target_valid, busy;

    int checks = 0;
    int errors = 0;

    target_select_fsm #(.BIN_CM(BIN_CM), .DIST_W(DIST_W)) dut (
        .clk(clk), .reset(reset),
        .btn_ultra(btn_ultra), .btn_key(btn_key), .btn_back(btn_back),
        .key_valid(key_valid), .key_code(key_code),
        .dist_valid(dist_valid), .dist_axis(dist_axis), .dist_cm(dist_cm),
        .state(state), .x(x), .y(y), .target_valid(target_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // behavioural model
    bit rst, lu, lk, lb, pu, pk, pb;
    int m_mode, m_x, m_y, m_idx, m_cnt, m_res;
    bit m_tv, m_rel, m_ext, m_axis;
    byte unsigned digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    function automatic int digit_of(input logic [7:0] code);
        for (int i = 0; i < 10; i++) if (digit_codes[i] == code) return i;
        return -1;
    endfunction

    task automatic model_step(input bit kv, input logic [7:0] kc, input bit dv, input bit da, input int dc);
        bit eu, ek, eb;
        int d;
        eu = lu && !pu; ek = lk && !pk; eb = lb && !pb;
        pu = lu; pk = lk; pb = lb;
        m_tv = 1'b0;
        if (rst) begin
            m_mode = 0; m_x = 15; m_y = 15; m_idx = 0; m_cnt = 0; m_rel = 0; m_ext = 0;
            return;
        end
        if (m_mode == 0) begin
            m_x = 15; m_y = 15;
            if (eu != ek) begin
                m_mode = eu ? 1 : 2;
                m_idx = 0; m_rel = 0; m_ext = 0;
            end
        end else if (eb) begin
            m_mode = 0; m_x = 15; m_y = 15; m_cnt = 0;
        end else if (m_mode == 1) begin
            if (m_cnt > 0) begin
                if (m_cnt == 1) begin
                    if (m_axis) m_y = m_res; else m_x = m_res;
                    m_tv = 1'b1;
                end
                m_cnt--;
            end else if (dv) begin
                m_res  = (dc / BIN_CM > 9) ? 9 : dc / BIN_CM;
                m_cnt  = m_res + 1;
                m_axis = da;
            end
        end else if (kv) begin
            d = digit_of(kc);
            if (kc == 8'hF0) m_rel = 1;
            else if (kc == 8'hE0) m_ext = 1;
            else if (m_rel || m_ext) begin m_rel = 0; m_ext = 0; end
            else if (d >= 0) begin
                if (m_idx == 0) m_x = d; else if (m_idx == 1) m_y = d;
                if (m_idx < 2) m_idx++;
            end else if (kc == 8'h66) begin
                if (m_idx == 2) m_y = 15; else if (m_idx == 1) m_x = 15;
                if (m_idx > 0) m_idx--;
            end else if (kc == 8'h5A && m_idx == 2) begin
                m_tv = 1'b1; m_idx = 0;
            end else if (kc == 8'h76) begin
                m_mode = 0; m_x = 15; m_y = 15;
            end
        end
    endtask

    function automatic logic [11:0] dut_vec();
        return {state, x, y, target_valid, busy};
    endfunction

    function automatic logic [11:0] exp_vec();
        return {2'(m_mode), 4'(m_x), 4'(m_y), m_tv, m_cnt > 0};
    endfunction

    // drive one cycle of inputs, advance the model, sample 1 time unit after the edge
    task automatic step(input bit kv = 0, input logic [7:0] kc = 8'h00, input bit dv = 0, input bit da = 0, input int dc = 0);
        reset = rst; btn_ultra = lu; btn_key = lk; btn_back = lb;
        key_valid = kv; key_code = kc; dist_valid = dv; dist_axis = da; dist_cm = DIST_W'(dc);
        model_step(kv, kc, dv, da, dc);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; lk = 1;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (dut_vec() !== 12'h0FF_0 >> 0 && dut_vec() !== {2'b00, 4'hF, 4'hF, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_state act=%h exp=%h", dut_vec(), {2'b00, 4'hF, 4'hF, 2'b00});
        end
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (state !== 2'b00) begin errors++; $display("FAIL held_btn_no_edge act=%b exp=00", state); end
        end
        lk = 0; step();
        lk = 1; step();
        checks++;
        if (state !== 2'b10) begin errors++; $display("FAIL key_edge_to_keyb act=%b exp=10", state); end
    endtask

    task automatic test_keyboard_entry();
        byte unsigned seq [6] = '{8'h16, 8'hF0, 8'h16, 8'h26, 8'h5A, 8'h00};
        for (int i = 0; i < 6; i++) begin
            step(i < 5, seq[i]);
            checks++;
            if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL kb_entry[%0d] act=%h exp=%h", i, dut_vec(), exp_vec()); end
            if (i == 0) begin
                checks++;
                if (x !== 4'd1) begin errors++; $display("FAIL kb_x_first act=%h exp=1", x); end
            end
            if (i == 4) begin
                checks++;
                if ({target_valid, x, y} !== {1'b1, 4'd1, 4'd3}) begin
                    errors++; $display("FAIL kb_enter act=%h exp=%h", {target_valid, x, y}, {1'b1, 4'd1, 4'd3});
                end
            end
        end
    endtask

    task automatic test_backspace();
        byte unsigned seq [6] = '{8'h1E, 8'h66, 8'h66, 8'h66, 8'h25, 8'h5A};
        logic [3:0] want_x [6] = '{4'd2, 4'hF, 4'hF, 4'hF, 4'd4, 4'd4};
        for (int i = 0; i < 6; i++) begin
            step(1, seq[i]);
            checks++;
            if (dut_vec() !== exp_vec() || x !== want_x[i] || target_valid !== 1'b0) begin
                errors++; $display("FAIL backspace[%0d] act=%h exp=%h x_req=%h", i, dut_vec(), exp_vec(), want_x[i]);
            end
        end
        step();
        lb = 1; step();
        checks++;
        if (state !== 2'b00) begin errors++; $display("FAIL back_to_select act=%b exp=00", state); end
        lb = 0; lu = 1; step();
        checks++;
        if (state !== 2'b01) begin errors++; $display("FAIL ultra_entry act=%b exp=01", state); end
    endtask

    task automatic test_ultra();
        for (int c = 0; c < 5; c++) begin
            step(0, 8'h00, c == 0 || c == 2, 0, (c == 0) ? 37 : 80);
            checks++;
            if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL ultra37[%0d] act=%h exp=%h", c, dut_vec(), exp_vec()); end
            checks++;
            if (c < 4 && busy !== 1'b1) begin errors++; $display("FAIL ultra37_busy[%0d] act=%b exp=1", c, busy); end
            else if (c == 4 && {x, target_valid, busy} !== {4'd3, 1'b1, 1'b0}) begin
                errors++; $display("FAIL ultra37_result act=%h exp=%h", {x, target_valid, busy}, {4'd3, 2'b10});
            end
        end
        for (int c = 0; c < 11; c++) begin
            step(0, 8'h00, c == 0, 1, 250);
            checks++;
            if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL ultra250[%0d] act=%h exp=%h", c, dut_vec(), exp_vec()); end
        end
        checks++;
        if ({y, target_valid} !== {4'd9, 1'b1}) begin errors++; $display("FAIL ultra250_clamp act=%h exp=%h", {y, target_valid}, {4'd9, 1'b1}); end
    endtask

    task automatic test_back_abort();
        for (int c = 0; c < 5; c++) begin
            lb = (c == 4);
            step(0, 8'h00, c == 0, 0, 95);
        end
        checks++;
        if (dut_vec() !== {2'b00, 4'hF, 4'hF, 2'b00}) begin
            errors++; $display("FAIL back_abort act=%h exp=%h", dut_vec(), {2'b00, 4'hF, 4'hF, 2'b00});
        end
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if (dut_vec() !== exp_vec() || target_valid !== 1'b0) begin
                errors++; $display("FAIL back_abort_quiet[%0d] act=%h exp=%h", c, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_both_buttons();
        byte unsigned seq [6] = '{8'h16, 8'h26, 8'hE0, 8'h5A, 8'h00, 8'h5A};
        lu = 0; lk = 0; lb = 0; step();
        lu = 1; lk = 1; step(); step();
        checks++;
        if (state !== 2'b00) begin errors++; $display("FAIL both_edges act=%b exp=00", state); end
        lu = 0; lk = 0; step();
        lk = 1; step();
        for (int i = 0; i < 6; i++) begin
            step(seq[i] != 8'h00, seq[i]);
            checks++;
            if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL ext_enter[%0d] act=%h exp=%h", i, dut_vec(), exp_vec()); end
            checks++;
            if (target_valid !== (i == 5)) begin errors++; $display("FAIL ext_enter_tv[%0d] act=%b exp=%b", i, target_valid, i == 5); end
        end
    endtask

    task automatic test_random();
        byte unsigned pool [17] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                                    8'h46, 8'hF0, 8'hE0, 8'h66, 8'h5A, 8'h5A, 8'h76, 8'h1C};
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = int'($urandom_range(0, 31));
            if (r == 0) lu = !lu;
            else if (r == 1) lk = !lk;
            else if (r == 2 && $urandom_range(0, 3) == 0) lb = !lb;
            rst = ($urandom_range(0, 599) == 0);
            step($urandom_range(0, 2) == 0, pool[$urandom_range(0, 16)],
                 $urandom_range(0, 3) == 0, 1'($urandom), int'($urandom_range(0, 511)));
            checks++;
            if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL random[%0d] act=%h exp=%h", c, dut_vec(), exp_vec()); end
        end
    endtask

    initial begin
        rst = 1; lu = 0; lk = 0; lb = 0; pu = 0; pk = 0; pb = 0;
        m_mode = 0; m_x = 15; m_y = 15; m_idx = 0; m_cnt = 0; m_res = 0;
        m_tv = 0; m_rel = 0; m_ext = 0; m_axis = 0;
        test_reset();
        test_keyboard_entry();
        test_backspace();
        test_ultra();
        test_back_abort();
        test_both_buttons();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
